// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, the canonical
// NOP encoding and the fetch state encoding.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0 -- what a consumer should treat as "no instruction"
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // A byte address is word-aligned when its two low bits are clear
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating counter pair for fetch-side observability: accepted handshakes
// and stalled cycles. Counters hold while enable_i is low (fault state).
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] stall_cnt_d;

  // Next values: bump on event, but never wrap past all-ones
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (enable_i && fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (enable_i && stall_inc_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator. Owns the PC, addresses the combinational
// instruction ROM, registers each returned word with its PC and offers it to
// decode over valid/ready. Redirects replace the PC and flush the held word.
// Misaligned redirects and fetches past the ROM end lock the unit in FAULT
// until reset.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          XLEN       = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC   = '0,
  parameter int unsigned          IMEM_WORDS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [ILEN-1:0]  imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic             fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam logic [XLEN-3:0] IMEM_LIMIT = (XLEN-2)'(IMEM_WORDS);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;
  logic [ILEN-1:0] out_instr_q;
  logic [XLEN-1:0] out_pc_q;
  logic            fault_q;

  logic [XLEN-1:0] pc_d;
  logic            advance;
  logic            pc_out_of_range;
  logic            redirect_misaligned;

  // The output slot can take a new word when empty or being drained, unless a
  // redirect is flushing it this cycle
  assign advance             = (!out_valid_q || out_ready) && !redirect_valid;
  assign pc_out_of_range     = (pc_q[XLEN-1:2] >= IMEM_LIMIT);
  assign redirect_misaligned = !is_word_aligned(redirect_pc[1:0]);
  assign pc_d                = pc_q + XLEN'(4);

  // Fetch FSM: redirect beats everything, then advance (with range check),
  // otherwise stall; FAULT freezes everything until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_valid) begin
            pc_q        <= redirect_pc;
            out_valid_q <= 1'b0;
            if (redirect_misaligned) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end else if (advance) begin
            if (pc_out_of_range) begin
              state_q     <= FAULT;
              fault_q     <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              out_instr_q <= imem_rdata;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              pc_q        <= pc_d;
            end
          end
        end
        FAULT: begin
          out_valid_q <= 1'b0;
          fault_q     <= 1'b1;
        end
        default: begin
          state_q     <= FAULT;
          fault_q     <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign fault     = fault_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (state_q == RUN),
    .fetch_inc_i (out_valid_q && out_ready),
    .stall_inc_i (out_valid_q && !out_ready),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`else
  // Performance counters not built in this configuration
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch initiator: owns the PC and drives the word address into the 64-word combinational instruction ROM.
- Captures each returned word with its PC into an output register.
- Hands instruction/PC to decode over a valid/ready handshake; accepts branch/jump redirects.
- Sits between the instruction ROM and the decode stage; it is the requester side of the ROM's address/data interface.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_WORDS, 64, ROM depth in 32-bit words; fetch beyond it is a fault
XLEN, 32, address/data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to ROM, combinational copy of pc (ROM indexes [31:2])
imem_rdata  input  32  ROM data, valid same cycle as imem_addr
redirect_valid  input  1  load redirect_pc this cycle
redirect_pc  input  32  branch/jump target
out_valid  output  1  out_instr/out_pc hold a fetched instruction
out_ready  input  1  decode accepts when out_valid && out_ready
out_instr  output  32  fetched instruction
out_pc  output  32  byte address of out_instr
fault  output  1  sticky fetch fault (misaligned or out-of-range)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=RUN, out_valid=0, out_instr=0, out_pc=0, fault=0.
- The first capture happens on the first rising edge after rst_n deasserts.
- States: RUN, FAULT.
- RUN, advance condition: (!out_valid || out_ready) && !redirect_valid.
- RUN, on advance:
  - out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - Latency: ROM word appears at the output 1 cycle after pc presents it.
- RUN, stall (out_valid && !out_ready): pc, out_instr, out_pc hold; out_valid stays 1.
- RUN, redirect (highest priority, also wins over a simultaneous handshake):
  - pc<=redirect_pc, out_valid<=0; the held instruction is discarded.
  - The first post-redirect word is captured the following cycle.
- Fault detection:
  - redirect_valid with redirect_pc[1:0]!=0 → state<=FAULT.
  - pc[31:2] >= IMEM_WORDS when an advance would occur → state<=FAULT, no capture.
- FAULT:
  - fault=1, out_valid=0, pc frozen at the faulting address, all inputs ignored.
  - Exits only via reset.
- pc+4 is modulo 2^32; the wrap is unreachable in practice because the range check fires first.
- imem_addr=pc always, including in FAULT.
- Reset mid-stall or mid-redirect: immediate return to reset values; no partial output.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments per accepted handshake) and perf_stall_cnt[31:0] (increments per cycle with out_valid && !out_ready).
  - Both reset to 0, saturate at 32'hFFFF_FFFF, frozen in FAULT.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package fetch_pkg: XLEN, ILEN=32, INSTR_NOP=32'h0000_0013, fetch state enum {RUN, FAULT}.
- Sub-module fetch_perf_cnt: saturating counter pair, instantiated only under FETCH_PERF_CNT_EN.
- Everything else stays in instr_fetch.

Test Plan:
ROM loaded with words 0-2=0, 3=0x00100093, 4=0x00B00113, 5=0x00000193, 6=0x00108093, 7=0x001181B3; remaining words 0.
- Reset, out_ready=1, 8 cycles → out_pc 0x00,0x04,…,0x1C on consecutive cycles; out_instr at 0x0C=0x00100093, 0x1C=0x001181B3; fault=0.
- Hold out_ready=0 when out_pc=0x10 for 3 cycles → out_instr stays 0x00B00113, imem_addr stays 0x14; release → next out_pc=0x14.
- redirect_valid=1, redirect_pc=0x0C, same cycle as an accepted handshake → next cycle out_valid=0; following cycle out_pc=0x0C, out_instr=0x00100093.
- redirect_pc=0x0000_0006 → fault=1 next cycle, out_valid=0 permanently; rst_n pulse → pc=RESET_PC, fault=0.
- Free-run past 0xFC → no capture at 0x100; fault=1, imem_addr=0x100.
- Assert rst_n=0 asynchronously mid-stall → outputs reset without a clock edge. With FETCH_PERF_CNT_EN: after the first test's 8 accepts, perf_fetch_cnt=8, perf_stall_cnt=0.
